// File: rtl/pc_ctrl.sv
// -----------------------------------------------------------------------------
// pc_ctrl -- front-end sequencing controller for the 5-stage pipeline.
//
// Each cycle this block decides whether the PC loads (sequential or redirect)
// or holds, and whether IF/ID loads, holds or is flushed to a NOP. It covers
// start-up, load-use stalls, branch/jump redirects resolved in ID, and
// instruction-memory wait states. A redirect that shows up while a fetch is
// still outstanding is parked in pend_pc and applied when the fetch completes.
//
// Optional feature macro: PC_CTRL_PERF_EN (adds stall_cnt_o / miss_cnt_o).
//
// Ports:
//   clk_i            clock, rising edge
//   rst_i            asynchronous reset, active-low
//   start_i          CPU run enable; 0 returns the FSM to IDLE
//   imem_ready_i     fetch data for the current PC is valid
//   idex_memread_i   instruction in EX is a load
//   idex_rt_i        load destination register
//   ifid_rs_i/rt_i   source registers of the instruction in ID
//   branch_taken_i   taken branch resolved in ID
//   branch_target_i  branch target
//   jump_i           jump in ID (wins over a simultaneous branch)
//   jump_target_i    jump target
//   pc_plus4_i       sequential next PC
//   pc_next_o        value presented to the PC input
//   pc_hold_o        1 = PC keeps its value
//   ifid_hold_o      1 = IF/ID keeps its value (overrides ifid_flush_o)
//   ifid_flush_o     1 = IF/ID loads a NOP
//   bubble_o         1 = zero control fields into ID/EX
//   state_o          FSM state (0 IDLE, 1 RUN, 2 IMISS)
//   stall_cnt_o      (PC_CTRL_PERF_EN) saturating hazard-bubble cycle count
//   miss_cnt_o       (PC_CTRL_PERF_EN) saturating imem wait-cycle count
// -----------------------------------------------------------------------------
module pc_ctrl #(
  parameter int unsigned AW = 32,
  parameter int unsigned RW = 5
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic          imem_ready_i,
  input  logic          idex_memread_i,
  input  logic [RW-1:0] idex_rt_i,
  input  logic [RW-1:0] ifid_rs_i,
  input  logic [RW-1:0] ifid_rt_i,
  input  logic          branch_taken_i,
  input  logic [AW-1:0] branch_target_i,
  input  logic          jump_i,
  input  logic [AW-1:0] jump_target_i,
  input  logic [AW-1:0] pc_plus4_i,
  output logic [AW-1:0] pc_next_o,
  output logic          pc_hold_o,
  output logic          ifid_hold_o,
  output logic          ifid_flush_o,
  output logic          bubble_o,
  output logic [1:0]    state_o
`ifdef PC_CTRL_PERF_EN
  ,
  output logic [15:0]   stall_cnt_o,
  output logic [15:0]   miss_cnt_o
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_IMISS = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          pend_vld_q, pend_vld_d;
  logic [AW-1:0] pend_pc_q, pend_pc_d;

  logic          hazard;
  logic          redir;
  logic [AW-1:0] tgt;

  assign hazard = idex_memread_i && (idex_rt_i != '0) &&
                  ((idex_rt_i == ifid_rs_i) || (idex_rt_i == ifid_rt_i));
  assign redir  = branch_taken_i || jump_i;
  assign tgt    = jump_i ? jump_target_i : branch_target_i;

  assign state_o = state_q;

  // Outputs are combinational from registered state/pend and current inputs,
  // so the PC and IF/ID registers see the decision in the same cycle.
  always_comb begin
    pc_next_o    = pc_plus4_i;
    pc_hold_o    = 1'b0;
    ifid_hold_o  = 1'b0;
    ifid_flush_o = 1'b0;
    bubble_o     = 1'b0;
    state_d      = state_q;
    pend_vld_d   = pend_vld_q;
    pend_pc_d    = pend_pc_q;

    case (state_q)
      ST_IDLE: begin
        pc_hold_o    = 1'b1;
        ifid_flush_o = 1'b1;
        bubble_o     = 1'b1;
        if (start_i) state_d = ST_RUN;
      end

      ST_RUN, ST_IMISS: begin
        if (!imem_ready_i) begin
          // Fetch outstanding: freeze PC, feed NOPs into ID. A redirect seen
          // now (and not blocked by a hazard) is parked until the fetch lands;
          // a later one overwrites it since it is the younger decision.
          state_d      = ST_IMISS;
          pc_hold_o    = 1'b1;
          ifid_flush_o = 1'b1;
          if (hazard) begin
            ifid_hold_o = 1'b1;
            bubble_o    = 1'b1;
          end else if (redir) begin
            pend_vld_d = 1'b1;
            pend_pc_d  = tgt;
          end
        end else if (state_q == ST_RUN) begin
          if (hazard) begin
            // Redirect deliberately ignored: ID re-evaluates it next cycle.
            pc_hold_o   = 1'b1;
            ifid_hold_o = 1'b1;
            bubble_o    = 1'b1;
          end else if (redir) begin
            pc_next_o    = tgt;
            ifid_flush_o = 1'b1;
          end
        end else begin
          state_d = ST_RUN;
          if (pend_vld_q) begin
            // The word just fetched is wrong-path; discard it and jump.
            pc_next_o    = pend_pc_q;
            ifid_flush_o = 1'b1;
            pend_vld_d   = 1'b0;
            if (hazard) begin
              ifid_hold_o = 1'b1;
              bubble_o    = 1'b1;
            end
          end else if (hazard) begin
            pc_hold_o   = 1'b1;
            ifid_hold_o = 1'b1;
            bubble_o    = 1'b1;
          end
        end
      end

      default: begin
        state_d      = ST_IDLE;
        pc_hold_o    = 1'b1;
        ifid_flush_o = 1'b1;
        bubble_o     = 1'b1;
      end
    endcase

    if (!start_i) begin
      state_d    = ST_IDLE;
      pend_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= ST_IDLE;
      pend_vld_q <= 1'b0;
      pend_pc_q  <= '0;
    end else begin
      state_q    <= state_d;
      pend_vld_q <= pend_vld_d;
      pend_pc_q  <= pend_pc_d;
    end
  end

`ifdef PC_CTRL_PERF_EN
  logic active;
  logic stall_inc;
  logic miss_inc;

  // Every non-IDLE cycle with a hazard raises a bubble, and every non-IDLE
  // cycle with imem not ready is a wait state.
  assign active    = (state_q != ST_IDLE);
  assign stall_inc = active && hazard;
  assign miss_inc  = active && !imem_ready_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_o <= '0;
      miss_cnt_o  <= '0;
    end else begin
      if (stall_inc && (stall_cnt_o != '1)) stall_cnt_o <= stall_cnt_o + 16'd1;
      if (miss_inc && (miss_cnt_o != '1))   miss_cnt_o  <= miss_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: doc/pc_ctrl.md
# pc_ctrl

Front-end sequencing controller for the 5-stage pipeline. Decides each cycle whether the PC register loads, holds, or takes a redirect, and whether the IF/ID register loads, holds, or is flushed. Covers start-up, load-use hazard stalls, branch/jump redirects resolved in ID, and instruction-memory wait states, including a redirect that arrives while a fetch is still outstanding. Sits between hazard/branch logic in ID and the PC, IF/ID and ID/EX control registers.

## Interface
- AW, 32, address/PC width
- RW, 5, register-index width
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous reset, active-low
- start_i  in  1  CPU run enable; 0 forces IDLE
- imem_ready_i  in  1  fetch data for current PC valid; stays high and data stable while PC is unchanged
- idex_memread_i  in  1  instruction in EX is a load
- idex_rt_i  in  RW  load destination register
- ifid_rs_i, ifid_rt_i  in  RW each  source registers of the instruction in ID
- branch_taken_i  in  1  taken branch resolved in ID
- branch_target_i  in  AW  branch target
- jump_i  in  1  jump in ID
- jump_target_i  in  AW  jump target
- pc_plus4_i  in  AW  sequential next PC
- pc_next_o  out  AW  value presented to PC input
- pc_hold_o  out  1  1 = PC keeps its value (PC write suppressed)
- ifid_hold_o  out  1  1 = IF/ID keeps its value; overrides ifid_flush_o
- ifid_flush_o  out  1  1 = IF/ID loads a NOP
- bubble_o  out  1  1 = zero control fields into ID/EX
- state_o  out  2  FSM state (0 IDLE, 1 RUN, 2 IMISS)

## Operation
- Definitions:
  - hazard = idex_memread_i & (idex_rt_i != 0) & (idex_rt_i == ifid_rs_i | idex_rt_i == ifid_rt_i)
  - redir = branch_taken_i | jump_i
  - tgt = jump_i ? jump_target_i : branch_target_i
- Internal registers: pend_vld, pend_pc[AW-1:0]; both reset to 0.
- Default outputs: pc_next_o = pc_plus4_i; all control outputs 0.
- IDLE:
  - Outputs: pc_hold=1, ifid_flush=1, bubble=1.
  - start_i=1 → RUN next cycle.
- RUN, imem_ready_i=1, evaluated in priority order:
  - hazard → pc_hold=1, ifid_hold=1, bubble=1. Any redirect is ignored; ID re-evaluates it next cycle.
  - redir → pc_next=tgt, ifid_flush=1.
  - else → sequential advance.
- RUN, imem_ready_i=0 → pc_hold=1, ifid_flush=1; next state IMISS.
  - If hazard: ifid_hold=1, bubble=1.
  - Else if redir: pend_pc←tgt, pend_vld←1. The branch proceeds to EX.
- IMISS, imem_ready_i=0:
  - Same outputs as the RUN miss cycle.
  - A new redir without hazard overwrites pend.
- IMISS, imem_ready_i=1, next state RUN:
  - pend_vld → pc_next=pend_pc, pc_hold=0, ifid_flush=1 (wrong-path fetch discarded), pend_vld←0. If hazard: also ifid_hold=1, bubble=1.
  - else if hazard → hold/bubble as in RUN.
  - else → sequential advance.
- start_i=0 in any state → next IDLE, pend_vld←0.

## Timing
- All outputs are combinational from registered state/pend plus current inputs, so response is in the same cycle (zero latency).
- State and pend update on the rising clock edge.
- Reset asserted, or held low: state=IDLE, state_o=0, pc_hold_o=1, ifid_hold_o=0, ifid_flush_o=1, bubble_o=1, pc_next_o=pc_plus4_i, pend cleared.
- Reset mid-IMISS discards any pending redirect.
- Load-use stall: exactly one cycle per hazard with single-cycle data memory. Hazard persisting for N cycles gives N stall cycles.
- Redirect during a miss is applied in the cycle imem_ready_i rises. Total PC-load latency = miss length.
- Both branch_taken_i and jump_i high: jump wins.

## Configuration
- PC_CTRL_PERF_EN defined: adds outputs stall_cnt_o[15:0] and miss_cnt_o[15:0].
  - stall_cnt_o counts cycles with hazard-induced bubble.
  - miss_cnt_o counts cycles with imem_ready_i=0 in RUN/IMISS.
  - Both saturate at 0xFFFF, async-clear on reset, and do not clear on start_i.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Test plan
- Reset low 2 cycles, start_i=0 → state_o=0, pc_hold_o=1, bubble_o=1. Raise start_i with pc_plus4_i=0x4 → next cycle state_o=1, pc_hold_o=0, pc_next_o=0x4.
- RUN, ready=1, idex_memread=1, idex_rt=8, ifid_rs=8 → pc_hold=1, ifid_hold=1, bubble=1. Repeat with idex_rt=0 → no stall.
- RUN, ready=1, branch_taken=1, target 0x40 → pc_next=0x40, pc_hold=0, ifid_flush=1. Add jump_i=1 with jump_target 0x100 → pc_next=0x100.
- ready=0 with branch to 0x80 → pc_hold=1, state_o=2. ready=0 for 3 more cycles, then ready=1 → pc_next=0x80, pc_hold=0, ifid_flush=1, state_o=1 next. With PERF: miss_cnt=4.
- Hazard and branch_taken (target 0x40) same cycle → pc_hold=1, ifid_flush=0, pc_next≠0x40.
- Async reset pulse during IMISS with pend set, then start_i=1 and ready=1 → no redirect to old target. pc_next=pc_plus4; counters read 0.
